// File: rtl/pipe_mem_pkg.sv
// Shared encodings for the MEM stage: access-size codes, FSM states and
// the byte-enable patterns used by the lane aligner.
package pipe_mem_pkg;

    localparam logic [1:0] DMEM_WORD = 2'b00;
    localparam logic [1:0] DMEM_HALF = 2'b01;
    localparam logic [1:0] DMEM_BYTE = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction/extension. Encoding 11 behaves like a word access;
// a word ignores the offset and a half only looks at offset[1].
module mem_lane_align
    import pipe_mem_pkg::*;
(
    input  logic [1:0]  in_type,
    input  logic [1:0]  in_offset,
    input  logic        in_unsigned,
    input  logic [31:0] in_st_data,
    input  logic [31:0] in_ld_word,
    output logic [3:0]  out_be,
    output logic [31:0] out_st_data,
    output logic [31:0] out_ld_data
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Lane selection for the current access size and offset.
    always_comb begin
        out_be      = BE_WORD;
        out_st_data = in_st_data;
        out_ld_data = in_ld_word;
        half_s      = 16'h0000;
        byte_s      = 8'h00;
        case (in_type)
            DMEM_HALF: begin
                if (in_offset[1]) begin
                    out_be = BE_HALF_HI;
                    half_s = in_ld_word[31:16];
                end else begin
                    out_be = BE_HALF_LO;
                    half_s = in_ld_word[15:0];
                end
                out_st_data = {2{in_st_data[15:0]}};
                if (in_unsigned) begin
                    out_ld_data = {16'h0000, half_s};
                end else begin
                    out_ld_data = {{16{half_s[15]}}, half_s};
                end
            end
            DMEM_BYTE: begin
                out_be      = BE_BYTE0 << in_offset;
                byte_s      = in_ld_word[{in_offset, 3'b000} +: 8];
                out_st_data = {4{in_st_data[7:0]}};
                if (in_unsigned) begin
                    out_ld_data = {24'h000000, byte_s};
                end else begin
                    out_ld_data = {{24{byte_s[7]}}, byte_s};
                end
            end
            default: begin
                out_be      = BE_WORD;
                out_st_data = in_st_data;
                out_ld_data = in_ld_word;
            end
        endcase
    end

endmodule

// File: rtl/pipe_mem_access.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while an
// access is outstanding and registers results into MEM/WB.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned word/half accesses
// are squashed and flagged on out_misalign instead of being issued).
module pipe_mem_access
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_dmem_ena,
    input  logic              in_dmem_wena,
    input  logic [1:0]        in_dmem_type,
    input  logic              in_dmem_unsigned,
    input  logic [ADDR_W-1:0] in_alu_result,
    input  logic [31:0]       in_rt_data,
    input  logic [4:0]        in_rd_waddr,
    input  logic              in_rd_sel,
    input  logic              in_rd_wena,
    output logic              out_stall,
    output logic              out_mem_req,
    output logic              out_mem_we,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [3:0]        out_mem_be,
    output logic [31:0]       out_mem_wdata,
    input  logic              in_mem_ack,
    input  logic [31:0]       in_mem_rdata,
    output logic [4:0]        out_rd_waddr,
    output logic              out_rd_sel,
    output logic              out_rd_wena,
    output logic [31:0]       out_alu_result,
    output logic [31:0]       out_load_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              out_misalign
`endif
);

    mem_state_e  state_r;
    logic [1:0]  hold_type_r;
    logic [1:0]  hold_off_r;
    logic        hold_unsigned_r;
    logic [4:0]  hold_waddr_r;
    logic        hold_sel_r;
    logic        hold_wena_r;
    logic [31:0] hold_alu_r;

    logic        misalign_s;
    logic        issue_s;
    logic [1:0]  sel_type_s;
    logic [1:0]  sel_off_s;
    logic        sel_unsigned_s;
    logic [3:0]  be_s;
    logic [31:0] st_data_s;
    logic [31:0] ld_data_s;
    logic [31:0] alu_ext_s;

    assign alu_ext_s = 32'(in_alu_result);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = in_dmem_ena &
                        ((((in_dmem_type == DMEM_WORD) || (in_dmem_type == 2'b11)) &&
                          (in_alu_result[1:0] != 2'b00)) ||
                         ((in_dmem_type == DMEM_HALF) && in_alu_result[0]));
`else
    assign misalign_s = 1'b0;
`endif

    assign issue_s = in_dmem_ena & ~misalign_s;

    // Stall is combinational so ack releases upstream in the same cycle; it is
    // forced low while reset is asserted.
    assign out_stall = in_rst_n & (((state_r == IDLE) & issue_s) |
                                   ((state_r == BUSY) & ~in_mem_ack));

    // Aligner sees live inputs at issue time and the held access during BUSY.
    always_comb begin
        if (state_r == BUSY) begin
            sel_type_s     = hold_type_r;
            sel_off_s      = hold_off_r;
            sel_unsigned_s = hold_unsigned_r;
        end else begin
            sel_type_s     = in_dmem_type;
            sel_off_s      = in_alu_result[1:0];
            sel_unsigned_s = in_dmem_unsigned;
        end
    end

    mem_lane_align u_lane_align (
        .in_type     (sel_type_s),
        .in_offset   (sel_off_s),
        .in_unsigned (sel_unsigned_s),
        .in_st_data  (in_rt_data),
        .in_ld_word  (in_mem_rdata),
        .out_be      (be_s),
        .out_st_data (st_data_s),
        .out_ld_data (ld_data_s)
    );

    // Two-state access FSM with registered memory-side and MEM/WB outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r         <= IDLE;
            out_mem_req     <= 1'b0;
            out_mem_we      <= 1'b0;
            out_mem_addr    <= '0;
            out_mem_be      <= 4'b0000;
            out_mem_wdata   <= 32'h0000_0000;
            out_rd_waddr    <= 5'd0;
            out_rd_sel      <= 1'b0;
            out_rd_wena     <= 1'b0;
            out_alu_result  <= 32'h0000_0000;
            out_load_data   <= 32'h0000_0000;
            hold_type_r     <= 2'b00;
            hold_off_r      <= 2'b00;
            hold_unsigned_r <= 1'b0;
            hold_waddr_r    <= 5'd0;
            hold_sel_r      <= 1'b0;
            hold_wena_r     <= 1'b0;
            hold_alu_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    out_rd_waddr   <= in_rd_waddr;
                    out_rd_sel     <= in_rd_sel;
                    out_alu_result <= alu_ext_s;
                    out_load_data  <= 32'h0000_0000;
                    if (issue_s) begin
                        state_r         <= BUSY;
                        out_mem_req     <= 1'b1;
                        out_mem_we      <= in_dmem_wena;
                        out_mem_addr    <= {in_alu_result[ADDR_W-1:2], 2'b00};
                        out_mem_be      <= be_s;
                        out_mem_wdata   <= st_data_s;
                        out_rd_wena     <= 1'b0;
                        hold_type_r     <= in_dmem_type;
                        hold_off_r      <= in_alu_result[1:0];
                        hold_unsigned_r <= in_dmem_unsigned;
                        hold_waddr_r    <= in_rd_waddr;
                        hold_sel_r      <= in_rd_sel;
                        hold_wena_r     <= in_rd_wena;
                        hold_alu_r      <= alu_ext_s;
                    end else begin
                        out_mem_req <= 1'b0;
                        out_rd_wena <= in_rd_wena & ~misalign_s;
                    end
                end
                BUSY: begin
                    if (in_mem_ack) begin
                        state_r        <= IDLE;
                        out_mem_req    <= 1'b0;
                        out_rd_waddr   <= hold_waddr_r;
                        out_rd_sel     <= hold_sel_r;
                        out_rd_wena    <= hold_wena_r;
                        out_alu_result <= hold_alu_r;
                        out_load_data  <= ld_data_s;
                    end else begin
                        out_mem_req <= 1'b1;
                        out_rd_wena <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_mem_req <= 1'b0;
                    out_rd_wena <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle flag for an access squashed because of misalignment.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_misalign <= 1'b0;
        end else begin
            out_misalign <= (state_r == IDLE) & misalign_s;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mem_access.sv
// Directed, table-driven bench for pipe_mem_access.
module tb_pipe_mem_access;

    logic        in_clk;
    logic        in_rst_n;
    logic        in_dmem_ena;
    logic        in_dmem_wena;
    logic [1:0]  in_dmem_type;
    logic        in_dmem_unsigned;
    logic [31:0] in_alu_result;
    logic [31:0] in_rt_data;
    logic [4:0]  in_rd_waddr;
    logic        in_rd_sel;
    logic        in_rd_wena;
    logic        out_stall;
    logic        out_mem_req;
    logic        out_mem_we;
    logic [31:0] out_mem_addr;
    logic [3:0]  out_mem_be;
    logic [31:0] out_mem_wdata;
    logic        in_mem_ack;
    logic [31:0] in_mem_rdata;
    logic [4:0]  out_rd_waddr;
    logic        out_rd_sel;
    logic        out_rd_wena;
    logic [31:0] out_alu_result;
    logic [31:0] out_load_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic        out_misalign;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pipe_mem_access #(.ADDR_W(32)) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_dmem_ena      (in_dmem_ena),
        .in_dmem_wena     (in_dmem_wena),
        .in_dmem_type     (in_dmem_type),
        .in_dmem_unsigned (in_dmem_unsigned),
        .in_alu_result    (in_alu_result),
        .in_rt_data       (in_rt_data),
        .in_rd_waddr      (in_rd_waddr),
        .in_rd_sel        (in_rd_sel),
        .in_rd_wena       (in_rd_wena),
        .out_stall        (out_stall),
        .out_mem_req      (out_mem_req),
        .out_mem_we       (out_mem_we),
        .out_mem_addr     (out_mem_addr),
        .out_mem_be       (out_mem_be),
        .out_mem_wdata    (out_mem_wdata),
        .in_mem_ack       (in_mem_ack),
        .in_mem_rdata     (in_mem_rdata),
        .out_rd_waddr     (out_rd_waddr),
        .out_rd_sel       (out_rd_sel),
        .out_rd_wena      (out_rd_wena),
        .out_alu_result   (out_alu_result),
        .out_load_data    (out_load_data)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .out_misalign     (out_misalign)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic        ena;
        logic        we;
        logic [1:0]  typ;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [4:0]  waddr;
        logic        sel;
        logic        wena;
        int          delay;
        logic [31:0] rdata;
        int          e_stall;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx);
        vec_t v;
        int   stalls;
        bit   acked;
        v      = vecs[idx];
        stalls = 0;
        acked  = 1'b0;
        @(negedge in_clk);
        in_dmem_ena      = v.ena;
        in_dmem_wena     = v.we;
        in_dmem_type     = v.typ;
        in_dmem_unsigned = v.uns;
        in_alu_result    = v.addr;
        in_rt_data       = v.rt;
        in_rd_waddr      = v.waddr;
        in_rd_sel        = v.sel;
        in_rd_wena       = v.wena;
        in_mem_ack       = 1'b0;
        in_mem_rdata     = v.rdata;
        #1;
        if (out_stall) stalls++;
        if (v.ena) begin
            @(posedge in_clk);
            #1;
            check("busy_req", idx, 32'(out_mem_req), 32'd1);
            check("busy_addr", idx, out_mem_addr, v.e_addr);
            check("busy_be", idx, 32'(out_mem_be), 32'(v.e_be));
            check("busy_we", idx, 32'(out_mem_we), 32'(v.we));
            if (v.we) check("busy_wdata", idx, out_mem_wdata, v.e_wdata);
            check("busy_bubble", idx, 32'(out_rd_wena), 32'd0);
            for (int b = 0; b < 20 && !acked; b++) begin
                @(negedge in_clk);
                in_mem_ack = (b == v.delay);
                #1;
                if (out_stall) stalls++;
                acked = in_mem_ack;
                @(posedge in_clk);
                #1;
                in_mem_ack = 1'b0;
            end
            check("ack_seen", idx, 32'(acked), 32'd1);
            check("done_req", idx, 32'(out_mem_req), 32'd0);
        end else begin
            @(posedge in_clk);
            #1;
            check("alu_req", idx, 32'(out_mem_req), 32'd0);
        end
        in_dmem_ena = 1'b0;
        check("stall_cycles", idx, 32'(stalls), 32'(v.e_stall));
        check("wb_waddr", idx, 32'(out_rd_waddr), 32'(v.waddr));
        check("wb_sel", idx, 32'(out_rd_sel), 32'(v.sel));
        check("wb_wena", idx, 32'(out_rd_wena), 32'(v.wena));
        check("wb_alu", idx, out_alu_result, v.addr);
        check("wb_load", idx, out_load_data, v.e_load);
    endtask

    initial begin
        //            ena  we    typ    uns   addr          rt            wad    sel   wena  dly rdata         stl e_addr        e_be     e_wdata       e_load
        vecs[0] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0,        5'd5,  1'b0, 1'b1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0013, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b0, 3, 32'h0,        4, 32'h0000_0010, 4'b1000, 32'hDDDD_DDDD, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        5'd7,  1'b1, 1'b1, 0, 32'h8001_0000, 1, 32'h0000_0020, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        5'd8,  1'b1, 1'b1, 0, 32'h8001_0000, 1, 32'h0000_0020, 4'b1100, 32'h0,        32'h0000_8001};
        vecs[4] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0,        5'd9,  1'b1, 1'b1, 1, 32'h1234_F600, 2, 32'h0000_0040, 4'b0010, 32'h0,        32'hFFFF_FFF6};
        vecs[5] = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 0, 32'h0,        1, 32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0,        5'd10, 1'b1, 1'b1, 2, 32'hCAFE_BABE, 3, 32'h0000_0040, 4'b1111, 32'h0,        32'hCAFE_BABE};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,        5'd11, 1'b1, 1'b1, 0, 32'h8000_0001, 1, 32'h0000_0008, 4'b1111, 32'h0,        32'h8000_0001};
        vecs[8] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0003, 32'h0,        5'd12, 1'b1, 1'b1, 0, 32'h9A00_0000, 1, 32'h0000_0000, 4'b1000, 32'h0,        32'h0000_009A};

        in_rst_n = 1'b0;
        in_dmem_ena = 1'b0; in_dmem_wena = 1'b0; in_dmem_type = 2'b00; in_dmem_unsigned = 1'b0;
        in_alu_result = 32'h0; in_rt_data = 32'h0; in_rd_waddr = 5'd0; in_rd_sel = 1'b0;
        in_rd_wena = 1'b0; in_mem_ack = 1'b0; in_mem_rdata = 32'h0;
        #12;
        check("rst_req", 0, 32'(out_mem_req), 32'd0);
        check("rst_stall", 0, 32'(out_stall), 32'd0);
        check("rst_addr", 0, out_mem_addr, 32'h0);
        check("rst_be", 0, 32'(out_mem_be), 32'd0);
        check("rst_wena", 0, 32'(out_rd_wena), 32'd0);
        check("rst_alu", 0, out_alu_result, 32'h0);
        check("rst_load", 0, out_load_data, 32'h0);
        @(negedge in_clk);
        in_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) apply(i);

        // Back-to-back word loads: second issues in the IDLE cycle after ack.
        @(negedge in_clk);
        in_dmem_ena = 1'b1; in_dmem_wena = 1'b0; in_dmem_type = 2'b00; in_dmem_unsigned = 1'b0;
        in_alu_result = 32'h0000_0040; in_rd_waddr = 5'd1; in_rd_sel = 1'b1; in_rd_wena = 1'b1;
        @(posedge in_clk); #1;
        check("b2b_addr0", 0, out_mem_addr, 32'h0000_0040);
        check("b2b_req0", 0, 32'(out_mem_req), 32'd1);
        @(negedge in_clk);
        in_mem_ack = 1'b1; in_mem_rdata = 32'h1111_AAAA;
        @(posedge in_clk); #1;
        in_mem_ack = 1'b0;
        check("b2b_req_gap", 0, 32'(out_mem_req), 32'd0);
        check("b2b_wb0_addr", 0, 32'(out_rd_waddr), 32'd1);
        check("b2b_wb0_wena", 0, 32'(out_rd_wena), 32'd1);
        check("b2b_wb0_data", 0, out_load_data, 32'h1111_AAAA);
        in_alu_result = 32'h0000_0044; in_rd_waddr = 5'd2;
        #1;
        check("b2b_issue_stall", 0, 32'(out_stall), 32'd1);
        @(posedge in_clk); #1;
        check("b2b_addr1", 0, out_mem_addr, 32'h0000_0044);
        check("b2b_req1", 0, 32'(out_mem_req), 32'd1);
        check("b2b_bubble", 0, 32'(out_rd_wena), 32'd0);
        @(negedge in_clk);
        in_mem_ack = 1'b1; in_mem_rdata = 32'h2222_BBBB;
        @(posedge in_clk); #1;
        in_mem_ack = 1'b0;
        in_dmem_ena = 1'b0;
        check("b2b_wb1_addr", 0, 32'(out_rd_waddr), 32'd2);
        check("b2b_wb1_data", 0, out_load_data, 32'h2222_BBBB);
        check("b2b_wb1_alu", 0, out_alu_result, 32'h0000_0044);

        // Reset while BUSY drops req and stall at once; a later idle ack is ignored.
        @(negedge in_clk);
        in_dmem_ena = 1'b1; in_alu_result = 32'h0000_0080; in_rd_waddr = 5'd3; in_rd_wena = 1'b1;
        @(posedge in_clk); #1;
        check("rstb_req_before", 0, 32'(out_mem_req), 32'd1);
        @(negedge in_clk);
        in_rst_n = 1'b0;
        #1;
        check("rstb_req", 0, 32'(out_mem_req), 32'd0);
        check("rstb_stall", 0, 32'(out_stall), 32'd0);
        in_dmem_ena = 1'b0; in_rd_wena = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        in_mem_ack = 1'b1; in_mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("spur_stall", 0, 32'(out_stall), 32'd0);
        @(posedge in_clk); #1;
        in_mem_ack = 1'b0;
        check("spur_req", 0, 32'(out_mem_req), 32'd0);
        check("spur_load", 0, out_load_data, 32'h0);
        check("spur_wena", 0, 32'(out_rd_wena), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load is squashed and flagged for one cycle.
        @(negedge in_clk);
        in_dmem_ena = 1'b1; in_dmem_wena = 1'b0; in_dmem_type = 2'b00;
        in_alu_result = 32'h0000_0042; in_rd_waddr = 5'd4; in_rd_wena = 1'b1;
        #1;
        check("mis_stall", 0, 32'(out_stall), 32'd0);
        @(posedge in_clk); #1;
        in_dmem_ena = 1'b0;
        check("mis_req", 0, 32'(out_mem_req), 32'd0);
        check("mis_flag", 0, 32'(out_misalign), 32'd1);
        check("mis_wena", 0, 32'(out_rd_wena), 32'd0);
        @(posedge in_clk); #1;
        check("mis_flag_clr", 0, 32'(out_misalign), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
